ddr_req_arbiter: RTL and testbench

Sequences and shares the single DDR burst command path between the four cache-side requesters: ISA fetch, data read, jump-address read and data store. It accepts level requests with address and length, picks one winner by fixed priority with ISA anti-starvation aging, and issues one command at a time to the DDR cache interface. It holds that command until the burst completes, then returns a one-cycle done pulse to the winner. It sits between the ISA/DATA caches and the DDR cache interface, and replaces the ad-hoc request ordering in that interface.

---
 rtl/ddr_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ddr_req_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: shares the single DDR burst command path between the four
// cache-side requesters (ISA fetch, DATA read, JMP_ADDR read, DATA store).
// Fixed priority store > jmp > data > isa, with ISA aging so instruction
// fetch cannot be starved by a steady stream of data traffic. One command is
// outstanding at a time; the winner sees a one-cycle done pulse at the end.
module ddr_req_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int LEN_W        = 10,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    input  logic                  ddr_rdy,
    input  logic [3:0]            req,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*LEN_W-1:0]    req_len,
    output logic [3:0]            done,
    output logic [3:0]            grant,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [2:0]            cmd_type,
    output logic [ADDR_W-1:0]     cmd_addr,
    output logic [LEN_W-1:0]      cmd_len,
    input  logic                  cmd_done,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    localparam logic [7:0] AGE_LIM = 8'(STARVE_LIMIT);

    state_t              state, state_nxt;
    logic [1:0]          win_idx, win_idx_nxt;
    logic [3:0]          mask, mask_nxt;
    logic [7:0]          age;

    logic [3:0]          elig;
    logic                arb_go;
    logic [1:0]          win_sel;
    logic [3:0]          win_oh;
    logic [ADDR_W-1:0]   win_addr;
    logic [LEN_W-1:0]    win_len;

    logic [3:0]          grant_nxt, done_nxt;
    logic                cmd_valid_nxt;
    logic [2:0]          cmd_type_nxt;
    logic [ADDR_W-1:0]   cmd_addr_nxt;
    logic [LEN_W-1:0]    cmd_len_nxt;

    // Downstream command encoding for each requester index.
    function automatic logic [2:0] type_of(input logic [1:0] idx);
        case (idx)
            2'd0:    type_of = 3'd3;  // R_ISA
            2'd1:    type_of = 3'd4;  // R_DATA
            2'd2:    type_of = 3'd7;  // R_INT_ADDR
            default: type_of = 3'd5;  // W_DATA_STORE
        endcase
    endfunction

    // The just-served requester is masked for one IDLE cycle so it can drop req.
    assign elig    = req & ~mask;
    assign arb_go  = (state == IDLE) && ddr_rdy && (elig != 4'b0000);
    assign win_oh  = 4'b0001 << win_sel;
    assign win_addr = req_addr[int'(win_sel)*ADDR_W +: ADDR_W];
    assign win_len  = req_len[int'(win_sel)*LEN_W +: LEN_W];

    // Winner select: an aged ISA request jumps ahead of everything else.
    always_comb begin
        win_sel = 2'd0;
        if (elig[0] && (age >= AGE_LIM)) win_sel = 2'd0;
        else if (elig[3])                win_sel = 2'd3;
        else if (elig[2])                win_sel = 2'd2;
        else if (elig[1])                win_sel = 2'd1;
        else                             win_sel = 2'd0;
    end

    // State register.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a zero-length burst skips the command handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_go) state_nxt = (win_len == '0) ? DONE : ISSUE;
            ISSUE:   if (cmd_ready) state_nxt = BUSY;
            BUSY:    if (cmd_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output next-values; cmd_done is only honoured in BUSY.
    always_comb begin
        win_idx_nxt   = win_idx;
        mask_nxt      = mask;
        grant_nxt     = grant;
        done_nxt      = 4'b0000;
        cmd_valid_nxt = cmd_valid;
        cmd_type_nxt  = cmd_type;
        cmd_addr_nxt  = cmd_addr;
        cmd_len_nxt   = cmd_len;
        case (state)
            IDLE: begin
                mask_nxt = 4'b0000;
                if (arb_go) begin
                    win_idx_nxt   = win_sel;
                    grant_nxt     = win_oh;
                    cmd_type_nxt  = type_of(win_sel);
                    cmd_addr_nxt  = win_addr;
                    cmd_len_nxt   = win_len;
                    cmd_valid_nxt = (win_len != '0);
                    if (win_len == '0) done_nxt = win_oh;
                end
            end
            ISSUE:   if (cmd_ready) cmd_valid_nxt = 1'b0;
            BUSY:    if (cmd_done) done_nxt = 4'b0001 << win_idx;
            DONE: begin
                grant_nxt = 4'b0000;
                mask_nxt  = 4'b0001 << win_idx;
            end
            default: ;
        endcase
    end

    // Output and winner registers; every output comes straight from a flop.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            win_idx   <= 2'd0;
            mask      <= 4'b0000;
            grant     <= 4'b0000;
            done      <= 4'b0000;
            cmd_valid <= 1'b0;
            cmd_type  <= 3'd0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            busy      <= 1'b0;
        end else begin
            win_idx   <= win_idx_nxt;
            mask      <= mask_nxt;
            grant     <= grant_nxt;
            done      <= done_nxt;
            cmd_valid <= cmd_valid_nxt;
            cmd_type  <= cmd_type_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_len   <= cmd_len_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    // ISA wait counter: counts cycles ISA is pending but not granted, saturates.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst)                      age <= 8'd0;
        else if (!req[0] || grant[0]) age <= 8'd0;
        else if (age != 8'hFF)        age <= age + 8'd1;
    end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed bench for ddr_req_arbiter: a vector table of single arbitrations
// from a clean IDLE, then hand-written multi-cycle sequences. Two instances
// share all inputs: u_dut (default aging limit) and u_stv (aging limit 8).
module tb_ddr_req_arbiter;
    localparam int AW = 28;
    localparam int LW = 10;

    localparam logic [AW-1:0] A_TAB [4] = '{28'h0000010, 28'h00002A0, 28'h0003B00, 28'hFFFFFF0};
    localparam logic [LW-1:0] L_TAB [4] = '{10'd72, 10'd16, 10'd1, 10'd1023};
    localparam logic [2:0]    T_TAB [4] = '{3'd3, 3'd4, 3'd7, 3'd5};

    logic mem_clk = 1'b0;
    logic rst = 1'b1;
    logic ddr_rdy = 1'b0;
    logic cmd_ready = 1'b0;
    logic cmd_done = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [4*AW-1:0] req_addr;
    logic [4*LW-1:0] req_len;
    logic [AW-1:0] a_cur [4];
    logic [LW-1:0] l_cur [4];

    logic [3:0] m_done, m_grant, s_done, s_grant;
    logic m_valid, m_busy, s_valid, s_busy;
    logic [2:0] m_type, s_type;
    logic [AW-1:0] m_addr, s_addr;
    logic [LW-1:0] m_len, s_len;

    int n_cmp = 0;
    int n_err = 0;

    always #5 mem_clk = ~mem_clk;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = a_cur[g];
        assign req_len[g*LW +: LW]  = l_cur[g];
    end

    ddr_req_arbiter #(.ADDR_W(AW), .LEN_W(LW), .STARVE_LIMIT(64)) u_dut (
        .mem_clk(mem_clk), .rst(rst), .ddr_rdy(ddr_rdy), .req(req),
        .req_addr(req_addr), .req_len(req_len), .done(m_done), .grant(m_grant),
        .cmd_valid(m_valid), .cmd_ready(cmd_ready), .cmd_type(m_type),
        .cmd_addr(m_addr), .cmd_len(m_len), .cmd_done(cmd_done), .busy(m_busy)
    );

    ddr_req_arbiter #(.ADDR_W(AW), .LEN_W(LW), .STARVE_LIMIT(8)) u_stv (
        .mem_clk(mem_clk), .rst(rst), .ddr_rdy(ddr_rdy), .req(req),
        .req_addr(req_addr), .req_len(req_len), .done(s_done), .grant(s_grant),
        .cmd_valid(s_valid), .cmd_ready(cmd_ready), .cmd_type(s_type),
        .cmd_addr(s_addr), .cmd_len(s_len), .cmd_done(cmd_done), .busy(s_busy)
    );

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] zl;       // requesters whose length is forced to 0
        logic [3:0] e_grant;
        logic [2:0] e_type;
        logic       e_valid;
        logic [3:0] e_done;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        idx_of = 0;
        for (int k = 0; k < 4; k++) if (g[k]) idx_of = k;
    endfunction

    task automatic set_defaults();
        for (int k = 0; k < 4; k++) begin
            a_cur[k] = A_TAB[k];
            l_cur[k] = L_TAB[k];
        end
    endtask

    task automatic do_reset();
        req = 4'b0000;
        cmd_done = 1'b0;
        @(negedge mem_clk);
        rst = 1'b1;
        @(negedge mem_clk);
        rst = 1'b0;
    endtask

    // Wait for a grant, check the command fields, finish the burst after nb
    // cycles, check the done pulse, optionally drop that requester's req.
    task automatic serve(input bit use_stv, input int nb, input bit drop,
                         output int w, output logic [3:0] gm, output logic [3:0] gs);
        int cnt;
        logic [3:0] g, d;
        cnt = 0;
        w = -1;
        g = use_stv ? s_grant : m_grant;
        while (g == 4'b0000 && cnt < 40) begin
            @(negedge mem_clk);
            cnt++;
            g = use_stv ? s_grant : m_grant;
        end
        gm = m_grant;
        gs = s_grant;
        if (g == 4'b0000) begin
            n_cmp++;
            n_err++;
            $display("FAIL serve_grant_wait: no grant within 40 cycles");
            return;
        end
        w = idx_of(g);
        check("serve type", use_stv ? s_type : m_type, T_TAB[w]);
        check("serve addr", use_stv ? s_addr : m_addr, A_TAB[w]);
        check("serve len",  use_stv ? s_len  : m_len,  L_TAB[w]);
        repeat (nb) @(negedge mem_clk);
        cmd_done = 1'b1;
        @(negedge mem_clk);
        cmd_done = 1'b0;
        cnt = 0;
        d = use_stv ? s_done : m_done;
        while (d == 4'b0000 && cnt < 20) begin
            @(negedge mem_clk);
            cnt++;
            d = use_stv ? s_done : m_done;
        end
        check("serve done", d, g);
        if (drop) req[w] = 1'b0;
        @(negedge mem_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, w1, w2;
        logic [3:0] gm, gs;
        logic [AW-1:0] a_hold;
        logic [LW-1:0] l_hold;

        vt[0]  = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 3'd3, 1'b1, 4'b0000};
        vt[1]  = '{4'b0011, 1'b1, 4'b0000, 4'b0010, 3'd4, 1'b1, 4'b0000};
        vt[2]  = '{4'b0111, 1'b1, 4'b0000, 4'b0100, 3'd7, 1'b1, 4'b0000};
        vt[3]  = '{4'b1111, 1'b1, 4'b0000, 4'b1000, 3'd5, 1'b1, 4'b0000};
        vt[4]  = '{4'b0101, 1'b1, 4'b0000, 4'b0100, 3'd7, 1'b1, 4'b0000};
        vt[5]  = '{4'b1001, 1'b1, 4'b0000, 4'b1000, 3'd5, 1'b1, 4'b0000};
        vt[6]  = '{4'b0110, 1'b1, 4'b0000, 4'b0100, 3'd7, 1'b1, 4'b0000};
        vt[7]  = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 4'b0000};
        vt[8]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0, 4'b0000};
        vt[9]  = '{4'b0010, 1'b1, 4'b0010, 4'b0010, 3'd4, 1'b0, 4'b0010};
        vt[10] = '{4'b1100, 1'b1, 4'b1000, 4'b1000, 3'd5, 1'b0, 4'b1000};
        vt[11] = '{4'b0011, 1'b1, 4'b0001, 4'b0010, 3'd4, 1'b1, 4'b0000};

        set_defaults();

        // Reset state
        @(negedge mem_clk);
        check("reset grant", m_grant, 4'b0000);
        check("reset valid", m_valid, 1'b0);
        check("reset busy",  m_busy,  1'b0);
        check("reset type",  m_type,  3'd0);

        // Table: one arbitration from a clean IDLE per row
        for (int i = 0; i < 12; i++) begin
            do_reset();
            set_defaults();
            for (int k = 0; k < 4; k++) if (vt[i].zl[k]) l_cur[k] = '0;
            ddr_rdy = vt[i].rdy;
            req = vt[i].req;
            @(negedge mem_clk);
            check($sformatf("v%0d grant", i), m_grant, vt[i].e_grant);
            check($sformatf("v%0d type", i),  m_type,  vt[i].e_type);
            check($sformatf("v%0d valid", i), m_valid, vt[i].e_valid);
            check($sformatf("v%0d done", i),  m_done,  vt[i].e_done);
            if (vt[i].e_grant != 4'b0000) begin
                w = idx_of(vt[i].e_grant);
                check($sformatf("v%0d addr", i), m_addr, A_TAB[w]);
                check($sformatf("v%0d len", i),  m_len,  vt[i].zl[w] ? 10'd0 : L_TAB[w]);
            end
        end
        set_defaults();

        // Single ISA request, done pulse, busy drop, masked re-grant timing
        do_reset();
        ddr_rdy = 1'b1;
        cmd_ready = 1'b1;
        req = 4'b0001;
        @(negedge mem_clk);
        check("single grant", m_grant, 4'b0001);
        check("single valid", m_valid, 1'b1);
        check("single addr",  m_addr,  28'h10);
        check("single len",   m_len,   10'd72);
        @(negedge mem_clk);
        check("single busy",   m_busy,  1'b1);
        check("single vdrop",  m_valid, 1'b0);
        repeat (2) @(negedge mem_clk);
        cmd_done = 1'b1;
        @(negedge mem_clk);
        cmd_done = 1'b0;
        check("single done",  m_done, 4'b0001);
        check("single busy2", m_busy, 1'b1);
        @(negedge mem_clk);
        check("single done1cyc", m_done,  4'b0000);
        check("single idle",     m_busy,  1'b0);
        check("single gclr",     m_grant, 4'b0000);
        @(negedge mem_clk);
        check("single masked", m_grant, 4'b0000);
        @(negedge mem_clk);
        check("single regrant", m_grant, 4'b0001);

        // Priority: all four at once, each drops req on its own done
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            serve(1'b0, 2, 1'b1, w, gm, gs);
            check($sformatf("prio order %0d", k), w, 3 - k);
        end

        // Starvation, ISA + DATA held high, aging limit 8
        do_reset();
        req = 4'b0011;
        serve(1'b1, 5, 1'b0, w1, gm, gs);
        serve(1'b1, 5, 1'b0, w2, gm, gs);
        check("starve first",  w1, 1);
        check("starve second", w2, 0);
        serve(1'b1, 5, 1'b0, w, gm, gs);
        check("starve third", w, 1);

        // Starvation with JMP + DATA + ISA: aging decides the second arbitration
        do_reset();
        req = 4'b0111;
        serve(1'b1, 8, 1'b0, w, gm, gs);
        check("age3 first", w, 2);
        serve(1'b1, 8, 1'b0, w, gm, gs);
        check("age3 stv isa",   gs, 4'b0001);
        check("age3 dut data",  gm, 4'b0010);

        // ddr_rdy gating, then zero-length request
        do_reset();
        req = 4'b0010;
        l_cur[1] = '0;
        ddr_rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge mem_clk);
            check("gate grant", m_grant, 4'b0000);
        end
        check("gate age", u_dut.age, 8'd0);
        ddr_rdy = 1'b1;
        @(negedge mem_clk);
        check("zl grant", m_grant, 4'b0010);
        check("zl done",  m_done,  4'b0010);
        check("zl valid", m_valid, 1'b0);
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge mem_clk);
            check("zl valid after", m_valid, 1'b0);
            check("zl done after",  m_done,  4'b0000);
        end
        set_defaults();

        // Backpressure: fields hold while inputs move, cmd_done in ISSUE ignored
        do_reset();
        cmd_ready = 1'b0;
        req = 4'b0100;
        @(negedge mem_clk);
        check("bp grant", m_grant, 4'b0100);
        check("bp valid", m_valid, 1'b1);
        a_hold = A_TAB[2];
        l_hold = L_TAB[2];
        req = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            a_cur[2] = a_cur[2] + 28'h40;
            l_cur[2] = LW'(c + 5);
            cmd_done = (c == 4);
            @(negedge mem_clk);
            check("bp valid hold", m_valid, 1'b1);
            check("bp addr hold",  m_addr,  a_hold);
            check("bp len hold",   m_len,   l_hold);
            check("bp no done",    m_done,  4'b0000);
        end
        cmd_ready = 1'b1;
        cmd_done = 1'b1;
        @(negedge mem_clk);
        cmd_done = 1'b0;
        check("bp accept valid", m_valid, 1'b0);
        check("bp accept done",  m_done,  4'b0000);
        check("bp accept busy",  m_busy,  1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge mem_clk);
            check("bp wait done", m_done, 4'b0000);
        end
        cmd_done = 1'b1;
        @(negedge mem_clk);
        cmd_done = 1'b0;
        check("bp done", m_done, 4'b0100);
        set_defaults();

        // Reset in BUSY, then a fresh store grant one cycle after release
        do_reset();
        req = 4'b1000;
        @(negedge mem_clk);
        @(negedge mem_clk);
        check("rst pre busy", m_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst grant", m_grant, 4'b0000);
        check("rst valid", m_valid, 1'b0);
        check("rst busy",  m_busy,  1'b0);
        check("rst done",  m_done,  4'b0000);
        check("rst type",  m_type,  3'd0);
        check("rst addr",  m_addr,  28'd0);
        check("rst len",   m_len,   10'd0);
        @(negedge mem_clk);
        rst = 1'b0;
        @(negedge mem_clk);
        check("rst regrant", m_grant, 4'b1000);
        check("rst revalid", m_valid, 1'b1);
        check("rst retype",  m_type,  3'd5);
        req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
